// File: rtl/arb_mux.sv
// N-input arbitrating multiplexer with a registered output stage.
// Fixed-priority or round-robin grant; grants only when the output register can load.
module arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready
);

  logic               w_load;
  logic               w_any;
  logic [SW-1:0]      w_gidx;
  logic [WIDTH-1:0]   w_chan [N];
  logic [WIDTH-1:0]   w_sel_data;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SW-1:0]      r_out_src;
  logic [SW-1:0]      r_ptr;

  assign w_load = !r_out_valid || out_ready;

  // Circular search starting at r_ptr (round robin) or 0 (fixed priority).
  always_comb begin : grant_search
    int start;
    int idx;
    w_any  = 1'b0;
    w_gidx = '0;
    start  = (mode && N > 1) ? int'(r_ptr) : 0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = start + k;
      if (idx >= N) idx = idx - N;
      if (!w_any && in_valid[idx]) begin
        w_any  = 1'b1;
        w_gidx = SW'(idx);
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign w_chan[gi]   = in_data[gi*WIDTH +: WIDTH];
    assign in_ready[gi] = rst_n && w_load && w_any && (w_gidx == SW'(gi));
  end

  assign w_sel_data = w_chan[w_gidx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_data <= w_sel_data;
        r_out_src  <= w_gidx;
        if (mode && N > 1)
          r_ptr <= (w_gidx == SW'(N-1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_arb_mux.sv
// Scoreboard bench for arb_mux: directed scenarios then randomized traffic,
// checked against a queue-based reference model.
module tb_arb_mux;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SW-1:0]    out_src;
  logic             out_ready;

  int total = 0;
  int bad   = 0;
  bit started = 0;

  typedef struct {
    logic [W-1:0] d;
    int           s;
  } word_t;
  word_t sb[$];

  int m_ptr = 0;
  bit m_ov  = 0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .N(N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .out_ready(out_ready)
  );

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides the grant for the coming edge from the rules.
  always @(negedge clk) begin
    int g;
    int start;
    int c;
    bit load;
    logic [N-1:0] exp_rdy;
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(m_ov));
      if (rst_n === 1'b0) begin
        check("in_ready_rst", 64'(in_ready), 64'd0);
        m_ptr = 0;
        m_ov  = 0;
        sb.delete();
      end else begin
        g     = -1;
        load  = !m_ov || out_ready;
        start = mode ? m_ptr : 0;
        if (load) begin
          for (int k = 0; k < N; k++) begin
            c = (start + k) % N;
            if (g < 0 && in_valid[c]) g = c;
          end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        if (load) begin
          if (g >= 0) begin
            sb.push_back('{d: in_data[g*W +: W], s: g});
            if (mode) m_ptr = (g + 1) % N;
            m_ov = 1;
          end else begin
            m_ov = 0;
          end
        end
      end
    end
  end

  // Monitor: pops the expected word on every output handshake.
  bit           prev_stall = 0;
  logic [W-1:0] prev_data;
  logic [SW-1:0] prev_src;
  always @(negedge clk) begin
    word_t w;
    if (started && rst_n === 1'b1) begin
      if (prev_stall) begin
        check("hold_data", 64'(out_data), 64'(prev_data));
        check("hold_src", 64'(out_src), 64'(prev_src));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word actual=%0h required=none", out_data);
        end else begin
          w = sb.pop_front();
          check("out_data", 64'(out_data), 64'(w.d));
          check("out_src", 64'(out_src), 64'(w.s));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_src   = out_src;
    end else begin
      prev_stall = 0;
    end
  end

  task automatic step(input logic r, input logic m, input logic [N-1:0] v, input logic rdy);
    rst_n     = r;
    mode      = m;
    in_valid  = v;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    in_data   = {32'h3333_3333, 32'hCCCC_CCCC, 32'h5555_5555, 32'hAAAA_AAAA};
    @(posedge clk);
    #1;
    started = 1;
    step(1'b0, 1'b0, 4'b0000, 1'b0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_src", 64'(out_src), 64'd0);

    // Fixed priority
    step(1'b1, 1'b0, 4'b1010, 1'b1);
    check("fp_src", 64'(out_src), 64'd1);
    check("fp_data", 64'(out_data), 64'h5555_5555);

    // Drain
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_data", 64'(out_data), 64'h5555_5555);

    // Backpressure
    step(1'b1, 1'b0, 4'b0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'b0100, 1'b0);
      check("bp_data", 64'(out_data), 64'hAAAA_AAAA);
      check("bp_ready", 64'(in_ready), 64'd0);
    end
    step(1'b1, 1'b0, 4'b0100, 1'b1);
    check("bp_load_data", 64'(out_data), 64'hCCCC_CCCC);
    check("bp_load_src", 64'(out_src), 64'd2);

    // Round-robin fairness
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 4'b1111, 1'b1);
      check("rr_src", 64'(out_src), 64'(i % 4));
    end

    // Pointer wrap
    step(1'b1, 1'b1, 4'b0100, 1'b1);
    check("wrap_pre", 64'(out_src), 64'd2);
    step(1'b1, 1'b1, 4'b1001, 1'b1);
    check("wrap_g3", 64'(out_src), 64'd3);
    step(1'b1, 1'b1, 4'b1001, 1'b1);
    check("wrap_g0", 64'(out_src), 64'd0);

    // Mid-stream reset
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'b1111, 1'b1);
    step(1'b0, 1'b1, 4'b1111, 1'b1);
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_src", 64'(out_src), 64'd0);
    step(1'b1, 1'b1, 4'b1111, 1'b1);
    check("mrst_first", 64'(out_src), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) in_data[c*W +: W] = $urandom;
      step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
           N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    end
    step(1'b1, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b0, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
